aa_table_writer: RTL and testbench

- Hardware associative table: the writer side that populates and removes key/data entries.
- Owns insert/update/delete of keys plus a registered existence/read-back lookup port, so SVA checkers compare a registered `exists` flag instead of a live associative array.
- Sits between a request master (valid/ready) and any checker/consumer of the lookup port.
- Storage: DEPTH entries of {valid, key, data}, fully associative, parallel compare.

---
 rtl/aa_table_writer.sv | 229 ++++++++++++++++++++++
 tb/tb_aa_table_writer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/aa_table_writer.sv
// aa_table_writer: writer side of a fully associative key/data table.
// Accepts insert/update/delete requests over a valid/ready handshake, commits
// them one cycle after acceptance and holds a status response until it is
// taken. It also provides a registered lookup port that is independent of
// the request FSM.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake (ready only while idle)
//   req_op                  0 = insert/update, 1 = delete
//   req_key, req_data       request key and insert data
//   rsp_valid/rsp_ready     response handshake
//   rsp_status              00 INSERTED, 01 UPDATED, 10 DELETED, 11 ERR
//   lkp_key                 lookup key, sampled every edge
//   lkp_exists, lkp_data    registered lookup result (data 0 on miss)
//   count                   registered number of valid entries
module aa_table_writer #(
    parameter int unsigned KEY_W  = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [KEY_W-1:0]  req_key,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_status,
    input  logic [KEY_W-1:0]  lkp_key,
    output logic              lkp_exists,
    output logic [DATA_W-1:0] lkp_data,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ST_INSERTED = 2'b00;
    localparam logic [1:0] ST_UPDATED  = 2'b01;
    localparam logic [1:0] ST_DELETED  = 2'b10;
    localparam logic [1:0] ST_ERR      = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Table storage
    logic [DEPTH-1:0]  r_valid;
    logic [KEY_W-1:0]  r_key  [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [CNT_W-1:0]  r_count;

    // Latched request
    logic              r_req_op;
    logic [KEY_W-1:0]  r_req_key;
    logic [DATA_W-1:0] r_req_data;

    // Registered outputs
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [1:0]        r_rsp_status;
    logic              r_lkp_exists;
    logic [DATA_W-1:0] r_lkp_data;

    // Search results and commit controls
    logic              w_req_hit;
    logic [IDX_W-1:0]  w_req_hit_idx;
    logic              w_free;
    logic [IDX_W-1:0]  w_free_idx;
    logic              w_data_wr;
    logic              w_set_en;
    logic              w_clr_en;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [1:0]        w_status;
    logic              w_lkp_hit;
    logic [DATA_W-1:0] w_lkp_data;
    logic              w_dup;

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_status = r_rsp_status;
    assign lkp_exists = r_lkp_exists;
    assign lkp_data   = r_lkp_data;
    assign count      = r_count;

    // Match the latched key and find the lowest free slot (descending scan,
    // so the lowest index is the last one written).
    always_comb begin
        w_req_hit     = 1'b0;
        w_req_hit_idx = '0;
        w_free        = 1'b0;
        w_free_idx    = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_key[i] == r_req_key)) begin
                w_req_hit     = 1'b1;
                w_req_hit_idx = IDX_W'(i);
            end
            if (!r_valid[i]) begin
                w_free     = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    // Next-state and commit decode
    always_comb begin
        w_state_nxt = r_state;
        w_data_wr   = 1'b0;
        w_set_en    = 1'b0;
        w_clr_en    = 1'b0;
        w_wr_idx    = '0;
        w_status    = ST_ERR;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_RESP;
                if (!r_req_op) begin
                    if (w_req_hit) begin
                        w_data_wr = 1'b1;
                        w_wr_idx  = w_req_hit_idx;
                        w_status  = ST_UPDATED;
                    end else if (w_free) begin
                        w_data_wr = 1'b1;
                        w_set_en  = 1'b1;
                        w_wr_idx  = w_free_idx;
                        w_status  = ST_INSERTED;
                    end
                end else if (w_req_hit) begin
                    w_clr_en = 1'b1;
                    w_wr_idx = w_req_hit_idx;
                    w_status = ST_DELETED;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Lookup compare against the current (pre-commit) table
    always_comb begin
        w_lkp_hit  = 1'b0;
        w_lkp_data = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (r_valid[i] && (r_key[i] == lkp_key)) begin
                w_lkp_hit  = 1'b1;
                w_lkp_data = w_lkp_data | r_data[i];
            end
        end
    end

    // Control state, valid bits, count and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_count      <= '0;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_status <= ST_INSERTED;
            r_lkp_exists <= 1'b0;
            r_lkp_data   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= (w_state_nxt == S_IDLE);
            r_rsp_valid <= (w_state_nxt == S_RESP);
            if (r_state == S_EXEC) begin
                r_rsp_status <= w_status;
            end
            if (w_set_en) begin
                r_valid[w_wr_idx] <= 1'b1;
                r_count           <= r_count + CNT_W'(1);
            end else if (w_clr_en) begin
                r_valid[w_wr_idx] <= 1'b0;
                r_count           <= r_count - CNT_W'(1);
            end
            r_lkp_exists <= w_lkp_hit;
            r_lkp_data   <= w_lkp_data;
        end
    end

    // Request latch and key/data storage carry no reset
    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && req_valid) begin
            r_req_op   <= req_op;
            r_req_key  <= req_key;
            r_req_data <= req_data;
        end
        if (w_data_wr) begin
            r_data[w_wr_idx] <= r_req_data;
        end
        if (w_set_en) begin
            r_key[w_wr_idx] <= r_req_key;
        end
    end

    // Duplicate-key detector for the invariant check
    always_comb begin
        w_dup = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            for (int j = i + 1; j < int'(DEPTH); j++) begin
                if (r_valid[i] && r_valid[j] && (r_key[i] == r_key[j])) begin
                    w_dup = 1'b1;
                end
            end
        end
    end

    a_no_dup_key: assert property (@(posedge clk) disable iff (!rst_n) !w_dup);
    a_count_pop:  assert property (@(posedge clk) disable iff (!rst_n)
                                   $countones(r_valid) == int'(r_count));

endmodule

// File: tb/tb_aa_table_writer.sv
// Directed plus randomized bench for aa_table_writer against an
// associative-array reference model of the table.
module tb_aa_table_writer;

    localparam int unsigned DEPTH = 8;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [31:0] req_key;
    logic [31:0] req_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_status;
    logic [31:0] lkp_key;
    logic        lkp_exists;
    logic [31:0] lkp_data;
    logic [3:0]  count;

    int n_cmp;
    int n_err;

    logic [31:0] m_tab [logic [31:0]];

    aa_table_writer #(
        .KEY_W (32),
        .DATA_W(32),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_key   (req_key),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_status(rsp_status),
        .lkp_key   (lkp_key),
        .lkp_exists(lkp_exists),
        .lkp_data  (lkp_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: returns the expected status and updates the model
    function automatic logic [1:0] model_apply(input logic op, input logic [31:0] key,
                                               input logic [31:0] data);
        if (!op) begin
            if (m_tab.exists(key)) begin
                m_tab[key] = data;
                return 2'b01;
            end
            if (m_tab.num() < int'(DEPTH)) begin
                m_tab[key] = data;
                return 2'b00;
            end
            return 2'b11;
        end
        if (m_tab.exists(key)) begin
            m_tab.delete(key);
            return 2'b10;
        end
        return 2'b11;
    endfunction

    task automatic do_req(input logic op, input logic [31:0] key, input logic [31:0] data,
                          input int hold, input logic [1:0] exp_st,
                          output logic lk1, output logic lk2);
        int cyc;
        cyc = 0;
        lk2 = 1'b0;
        while (!req_ready && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("req_ready_idle", 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_op    = op;
        req_key   = key;
        req_data  = data;
        rsp_ready = (hold == 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("exec_req_ready", 64'(req_ready), 64'(0));
        chk("exec_rsp_valid", 64'(rsp_valid), 64'(0));
        @(posedge clk); #1;
        chk("rsp_valid", 64'(rsp_valid), 64'(1));
        chk("rsp_status", 64'(rsp_status), 64'(exp_st));
        lk1 = lkp_exists;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (i == 0) lk2 = lkp_exists;
            chk("hold_rsp_valid", 64'(rsp_valid), 64'(1));
            chk("hold_rsp_status", 64'(rsp_status), 64'(exp_st));
            chk("hold_req_ready", 64'(req_ready), 64'(0));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        if (hold == 0) lk2 = lkp_exists;
        chk("rsp_dropped", 64'(rsp_valid), 64'(0));
        chk("back_idle", 64'(req_ready), 64'(1));
    endtask

    task automatic step(input logic op, input logic [31:0] key, input logic [31:0] data,
                        input int hold);
        logic [1:0] e;
        logic a;
        logic b;
        e = model_apply(op, key, data);
        do_req(op, key, data, hold, e, a, b);
        chk("count_model", 64'(count), 64'(m_tab.num()));
    endtask

    task automatic lkp_chk(input logic [31:0] key);
        lkp_key = key;
        @(posedge clk); #1;
        chk("lkp_exists", 64'(lkp_exists), m_tab.exists(key) ? 64'(1) : 64'(0));
        chk("lkp_data", 64'(lkp_data), m_tab.exists(key) ? 64'(m_tab[key]) : 64'(0));
    endtask

    initial begin
        logic a;
        logic b;
        logic [1:0] e;
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 1'b0;
        req_key   = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        lkp_key   = '0;
        #12;
        chk("rst_req_ready", 64'(req_ready), 64'(1));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_status", 64'(rsp_status), 64'(0));
        chk("rst_lkp_exists", 64'(lkp_exists), 64'(0));
        chk("rst_lkp_data", 64'(lkp_data), 64'(0));
        chk("rst_count", 64'(count), 64'(0));
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Insert then update
        step(1'b0, 32'h10, 32'hAA, 0);
        chk("count_after_insert", 64'(count), 64'(1));
        lkp_chk(32'h10);
        chk("lkp_10_aa", 64'(lkp_data), 64'hAA);
        step(1'b0, 32'h10, 32'hBB, 0);
        chk("count_after_update", 64'(count), 64'(1));
        lkp_chk(32'h10);
        chk("lkp_10_bb", 64'(lkp_data), 64'hBB);
        lkp_chk(32'h11);
        chk("lkp_11_miss", 64'(lkp_exists), 64'(0));

        // Empty, then fill to capacity
        step(1'b1, 32'h10, 32'h0, 0);
        chk("count_empty", 64'(count), 64'(0));
        for (int k = 1; k <= 8; k++) step(1'b0, 32'(k), 32'(k * 16 + 5), 0);
        chk("count_full", 64'(count), 64'(8));
        step(1'b0, 32'd9, 32'h99, 0);
        chk("count_full_err", 64'(count), 64'(8));
        lkp_chk(32'd9);
        chk("lkp_9_miss", 64'(lkp_exists), 64'(0));

        // Delete, delete again, reuse the freed slot
        step(1'b1, 32'd3, 32'h0, 0);
        chk("count_del3", 64'(count), 64'(7));
        step(1'b1, 32'd3, 32'h0, 0);
        step(1'b0, 32'd9, 32'h99, 0);
        chk("count_ins9", 64'(count), 64'(8));
        lkp_chk(32'd9);

        // Lookup of key 5 across its own delete: old view at commit edge
        lkp_key = 32'd5;
        e = model_apply(1'b1, 32'd5, 32'h0);
        do_req(1'b1, 32'd5, 32'h0, 0, e, a, b);
        chk("lkp5_commit_edge", 64'(a), 64'(1));
        chk("lkp5_after_commit", 64'(b), 64'(0));

        // Response back-pressure for 4 cycles
        step(1'b0, 32'd5, 32'h55, 4);

        // Randomized traffic with a small key space to hit full/miss cases
        for (int n = 0; n < 60; n++) begin
            step(1'($urandom_range(0, 1)), 32'($urandom_range(1, 12)), $urandom,
                 int'($urandom_range(0, 2)));
            lkp_chk(32'($urandom_range(0, 13)));
        end

        // Reset during EXEC drops the request and empties the table
        req_valid = 1'b1;
        req_op    = 1'b0;
        req_key   = 32'h77;
        req_data  = 32'h1234;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        m_tab.delete();
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("mid_rst_count", 64'(count), 64'(0));
        chk("mid_rst_lkp", 64'(lkp_exists), 64'(0));
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_req_ready", 64'(req_ready), 64'(1));
        chk("post_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        lkp_chk(32'h77);
        lkp_chk(32'd1);
        lkp_chk(32'd9);
        step(1'b0, 32'h77, 32'h4321, 0);
        chk("post_rst_count", 64'(count), 64'(1));
        lkp_chk(32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
